// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode indices (one-hot bit positions seen by the
// multicycle controller), instruction field positions and fetch FSM states.
package decode_pkg;

  localparam int NOPS = 23;

  // Opcode values double as bit indices into the controller's one-hot vector
  localparam int OP_NOP  = 0;
  localparam int OP_LD   = 1;
  localparam int OP_ST   = 2;
  localparam int OP_LDI  = 3;
  localparam int OP_MV   = 4;
  localparam int OP_ADD  = 5;
  localparam int OP_SUB  = 6;
  localparam int OP_AND  = 7;
  localparam int OP_OR   = 8;
  localparam int OP_XOR  = 9;
  localparam int OP_NOT  = 10;
  localparam int OP_SHL  = 11;
  localparam int OP_SHR  = 12;
  localparam int OP_ADDI = 13;
  localparam int OP_SUBI = 14;
  localparam int OP_CMP  = 15;
  localparam int OP_BR   = 16;
  localparam int OP_BEQ  = 17;
  localparam int OP_BNE  = 18;
  localparam int OP_JMP  = 19;
  localparam int OP_CALL = 20;
  localparam int OP_RET  = 21;
  localparam int OP_HALT = 22;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int RA_MSB  = 10;
  localparam int RA_LSB  = 7;
  localparam int RB_MSB  = 6;
  localparam int RB_LSB  = 3;
  localparam int IMM_MSB = 6;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b01,
    S_DECODE = 2'b10
  } state_e;

endpackage

// File: rtl/opcode_onehot_dec.sv
// Combinational opcode -> one-hot translation; out-of-range opcodes give an
// all-zero vector and raise illegal.
module opcode_onehot_dec #(
  parameter int OPW  = 5,
  parameter int NOPS = 23
) (
  input  logic [OPW-1:0]  opcode,
  output logic [NOPS-1:0] onehot,
  output logic            illegal
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NOPS; i++) begin
      onehot[i] = (opcode == i[OPW-1:0]);
    end
    illegal = ~|onehot;
  end

endmodule

// File: rtl/instr_decode_unit.sv
// Fetch-side instruction register with load handshake, registered one-hot
// opcode decode, field extraction, sticky illegal flag and decode counter.
module instr_decode_unit
  import decode_pkg::*;
#(
  parameter int IW   = 16,
  parameter int OPW  = 5,
  parameter int NOPS = decode_pkg::NOPS,
  parameter int CNTW = 16
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            ir_load,
  input  logic            mem_valid,
  input  logic [IW-1:0]   mem_data,
  input  logic            illegal_clr,
  output logic [NOPS-1:0] op_onehot,
  output logic [3:0]      A_vec_4bits,
  output logic [3:0]      rb_field,
  output logic [6:0]      imm7,
  output logic [IW-1:0]   ir,
  output logic            busy,
  output logic            dec_valid,
  output logic            illegal_op,
  output logic [CNTW-1:0] instr_count
);

  state_e          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [NOPS-1:0] op_onehot_q, op_onehot_d;
  logic [3:0]      ra_q, ra_d;
  logic [3:0]      rb_q, rb_d;
  logic [6:0]      imm_q, imm_d;
  logic            dec_valid_q, dec_valid_d;
  logic            illegal_q, illegal_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [NOPS-1:0] dec_onehot;
  logic            dec_illegal;

  opcode_onehot_dec #(
    .OPW  (OPW),
    .NOPS (NOPS)
  ) u_dec (
    .opcode  (ir_q[IW-1 -: OPW]),
    .onehot  (dec_onehot),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    op_onehot_d = op_onehot_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    imm_d       = imm_q;
    dec_valid_d = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (ir_load) begin
          if (mem_valid) begin
            ir_d    = mem_data;
            state_d = S_DECODE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      // The request is remembered here; ir_load is no longer looked at
      S_WAIT: begin
        if (mem_valid) begin
          ir_d    = mem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_onehot_d = dec_onehot;
        ra_d        = ir_q[RA_MSB:RA_LSB];
        rb_d        = ir_q[RB_MSB:RB_LSB];
        imm_d       = ir_q[IMM_MSB:IMM_LSB];
        dec_valid_d = 1'b1;
        cnt_d       = cnt_q + CNTW'(1);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A fresh illegal decode overrides a coincident clear
  always_comb begin
    illegal_d = illegal_q;
    if (illegal_clr) illegal_d = 1'b0;
    if (state_q == S_DECODE && dec_illegal) illegal_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      op_onehot_q <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      imm_q       <= '0;
      dec_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      op_onehot_q <= op_onehot_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      imm_q       <= imm_d;
      dec_valid_q <= dec_valid_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ir          = ir_q;
  assign op_onehot   = op_onehot_q;
  assign A_vec_4bits = ra_q;
  assign rb_field    = rb_q;
  assign imm7        = imm_q;
  assign dec_valid   = dec_valid_q;
  assign illegal_op  = illegal_q;
  assign instr_count = cnt_q;
  assign busy        = (state_q == S_WAIT) || (state_q == S_DECODE);

endmodule

// File: tb/tb_instr_decode_unit.sv
// Randomized and directed bench for instr_decode_unit against a
// transaction-level model; a second instance with a 4-bit counter covers wrap.
module tb_instr_decode_unit;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        ir_load = 1'b0;
  logic        mem_valid = 1'b0;
  logic        illegal_clr = 1'b0;
  logic [15:0] mem_data = '0;

  logic [22:0] op_onehot;
  logic [3:0]  a_vec, rb_field;
  logic [6:0]  imm7;
  logic [15:0] ir;
  logic        busy, dec_valid, illegal_op;
  logic [15:0] instr_count;

  logic [22:0] w_oh;
  logic [3:0]  w_ra, w_rb;
  logic [6:0]  w_imm;
  logic [15:0] w_ir;
  logic        w_busy, w_dv, w_ill;
  logic [3:0]  w_cnt;

  int total = 0;
  int bad = 0;

  instr_decode_unit dut (
    .clock(clock), .resetn(resetn), .ir_load(ir_load), .mem_valid(mem_valid),
    .mem_data(mem_data), .illegal_clr(illegal_clr), .op_onehot(op_onehot),
    .A_vec_4bits(a_vec), .rb_field(rb_field), .imm7(imm7), .ir(ir), .busy(busy),
    .dec_valid(dec_valid), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  instr_decode_unit #(.CNTW(4)) u_wrap (
    .clock(clock), .resetn(resetn), .ir_load(ir_load), .mem_valid(mem_valid),
    .mem_data(mem_data), .illegal_clr(illegal_clr), .op_onehot(w_oh),
    .A_vec_4bits(w_ra), .rb_field(w_rb), .imm7(w_imm), .ir(w_ir), .busy(w_busy),
    .dec_valid(w_dv), .illegal_op(w_ill), .instr_count(w_cnt)
  );

  initial forever #5 clock = ~clock;

  // Reference model: a fetch request is pending or an instruction is held for decode
  logic [15:0] m_ir = '0;
  logic [22:0] m_oh = '0;
  logic [3:0]  m_ra = '0, m_rb = '0;
  logic [6:0]  m_imm = '0;
  logic        m_dv = 1'b0, m_ill = 1'b0, m_pend = 1'b0, m_have = 1'b0;
  int          m_cnt = 0;

  function automatic logic [22:0] ref_onehot(input logic [15:0] w);
    int op;
    op = int'(w >> 11);
    if (op < 23) return 23'(64'd1 << op);
    return 23'd0;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_ir <= '0; m_oh <= '0; m_ra <= '0; m_rb <= '0; m_imm <= '0;
      m_dv <= 1'b0; m_ill <= 1'b0; m_pend <= 1'b0; m_have <= 1'b0; m_cnt <= 0;
    end else if (m_have) begin
      m_oh   <= ref_onehot(m_ir);
      m_ra   <= 4'((m_ir >> 7) & 16'hF);
      m_rb   <= 4'((m_ir >> 3) & 16'hF);
      m_imm  <= 7'(m_ir & 16'h7F);
      m_dv   <= 1'b1;
      m_cnt  <= m_cnt + 1;
      m_have <= 1'b0;
      m_ill  <= (int'(m_ir >> 11) >= 23) ? 1'b1 : (illegal_clr ? 1'b0 : m_ill);
    end else begin
      m_dv <= 1'b0;
      if (illegal_clr) m_ill <= 1'b0;
      if ((m_pend || ir_load) && mem_valid) begin
        m_ir   <= mem_data;
        m_have <= 1'b1;
        m_pend <= 1'b0;
      end else begin
        m_pend <= m_pend || ir_load;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("ir", 64'(ir), 64'(m_ir));
    chk("op_onehot", 64'(op_onehot), 64'(m_oh));
    chk("ra", 64'(a_vec), 64'(m_ra));
    chk("rb", 64'(rb_field), 64'(m_rb));
    chk("imm7", 64'(imm7), 64'(m_imm));
    chk("dec_valid", 64'(dec_valid), 64'(m_dv));
    chk("illegal_op", 64'(illegal_op), 64'(m_ill));
    chk("busy", 64'(busy), 64'(m_pend | m_have));
    chk("instr_count", 64'(instr_count), 64'(m_cnt % 65536));
    chk("wrap_dut", 64'({w_oh, w_ra, w_rb, w_imm, w_ir, w_busy, w_dv, w_ill, w_cnt}),
        64'({m_oh, m_ra, m_rb, m_imm, m_ir, m_pend | m_have, m_dv, m_ill, 4'(m_cnt % 16)}));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [15:0] w);
    ir_load = 1'b1; mem_valid = 1'b1; mem_data = w;
    step();
    ir_load = 1'b0; mem_valid = 1'b0;
    step();
  endtask

  initial begin
    int bc;
    int pulses;
    #1 resetn = 1'b0;
    step(); step();
    chk("rst_ir", 64'(ir), 64'd0);
    chk("rst_onehot", 64'(op_onehot), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(instr_count), 64'd0);
    chk("rst_illegal", 64'(illegal_op), 64'd0);
    resetn = 1'b1;

    // Immediate capture, decode one edge later
    ir_load = 1'b1; mem_valid = 1'b1; mem_data = 16'h6080;
    step();
    chk("s1_busy", 64'(busy), 64'd1);
    chk("s1_dv_early", 64'(dec_valid), 64'd0);
    ir_load = 1'b0; mem_valid = 1'b0;
    step();
    chk("s1_onehot", 64'(op_onehot), 64'h001000);
    chk("s1_ra", 64'(a_vec), 64'd1);
    chk("s1_dv", 64'(dec_valid), 64'd1);
    chk("s1_count", 64'(instr_count), 64'd1);
    step();
    chk("s1_dv_drop", 64'(dec_valid), 64'd0);
    chk("s1_hold", 64'(op_onehot), 64'h001000);

    // Three wait cycles before memory answers
    bc = 0;
    ir_load = 1'b1; mem_valid = 1'b0;
    step(); bc += int'(busy);
    ir_load = 1'b0;
    step(); bc += int'(busy);
    step(); bc += int'(busy);
    mem_valid = 1'b1; mem_data = 16'hB3FF;
    step(); bc += int'(busy);
    mem_valid = 1'b0;
    step(); bc += int'(busy);
    chk("s2_busy_cycles", 64'(bc), 64'd4);
    chk("s2_onehot", 64'(op_onehot), 64'h400000);
    chk("s2_ra", 64'(a_vec), 64'h7);
    chk("s2_rb", 64'(rb_field), 64'hF);
    chk("s2_imm", 64'(imm7), 64'h7F);

    // Illegal opcode, sticky flag, clear, and set-wins-over-clear
    fetch(16'hF800);
    chk("s3_onehot", 64'(op_onehot), 64'd0);
    chk("s3_illegal", 64'(illegal_op), 64'd1);
    step(); step(); step();
    chk("s3_sticky", 64'(illegal_op), 64'd1);
    illegal_clr = 1'b1;
    step();
    illegal_clr = 1'b0;
    chk("s3_cleared", 64'(illegal_op), 64'd0);
    ir_load = 1'b1; mem_valid = 1'b1; mem_data = 16'hC000;
    step();
    ir_load = 1'b0; mem_valid = 1'b0; illegal_clr = 1'b1;
    step();
    illegal_clr = 1'b0;
    chk("s3_set_wins", 64'(illegal_op), 64'd1);

    // ir_load held high through decode must not capture twice
    ir_load = 1'b1; mem_valid = 1'b1; mem_data = 16'h0880;
    step();
    mem_data = 16'h1100;
    step();
    chk("s6_ir_kept", 64'(ir), 64'h0880);
    chk("s6_onehot", 64'(op_onehot), 64'h2);
    step();
    chk("s6_next_capture", 64'(ir), 64'h1100);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      pulses += int'(dec_valid);
    end
    chk("s6_pulses", 64'(pulses), 64'd5);
    ir_load = 1'b0; mem_valid = 1'b0;
    step();

    // Asynchronous reset while waiting for memory
    ir_load = 1'b1; mem_valid = 1'b0;
    step();
    ir_load = 1'b0;
    chk("s5_waiting", 64'(busy), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("s5_rst_all", 64'({op_onehot, a_vec, rb_field, imm7, ir, busy, dec_valid, illegal_op, instr_count}), 64'd0);
    step();
    resetn = 1'b1;
    fetch(16'h6080);
    chk("s5_onehot", 64'(op_onehot), 64'h001000);
    chk("s5_ra", 64'(a_vec), 64'd1);
    chk("s5_count", 64'(instr_count), 64'd1);
    chk("s5_dv", 64'(dec_valid), 64'd1);

    // Random traffic, with occasional mid-cycle resets
    for (int c = 0; c < 4000; c++) begin
      ir_load     = 1'($urandom_range(0, 1));
      mem_valid   = ($urandom_range(0, 9) < 4);
      mem_data    = 16'($urandom);
      illegal_clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 resetn = 1'b0;
        #4 resetn = 1'b1;
      end
      step();
    end
    ir_load = 1'b0; mem_valid = 1'b0; illegal_clr = 1'b0;
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_decode_unit.md
Name: instr_decode_unit

Overview:
Fetch-side counterpart of the multicycle controller. It captures the instruction word from memory into the instruction register under a load handshake. It decodes the opcode into the registered one-hot vector that the controller consumes, and extracts the register field it consumes alongside it. It also flags illegal opcodes and counts decoded instructions for debug.

Parameters:
IW, 16, instruction word width
OPW, 5, opcode width; opcode = instr[IW-1 -: OPW]
NOPS, 23, number of legal opcodes = one-hot vector width
CNTW, 16, decoded-instruction counter width

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
ir_load  in  1  request to fetch/latch next instruction (controller fetch control bit)
mem_valid  in  1  mem_data valid this cycle
mem_data  in  IW  instruction word from memory
illegal_clr  in  1  clears sticky illegal_op
op_onehot  out  NOPS  registered one-hot opcode (controller A_in)
A_vec_4bits  out  4  instr[10:7], register field A
rb_field  out  4  instr[6:3]
imm7  out  7  instr[6:0]
ir  out  IW  instruction register contents
busy  out  1  high in S_WAIT and S_DECODE
dec_valid  out  1  one-cycle pulse: decode outputs freshly updated
illegal_op  out  1  sticky illegal-opcode flag
instr_count  out  CNTW  count of completed decodes

Behaviour:
- Reset: clock-independent, all outputs 0 (ir, op_onehot, fields, busy, dec_valid, illegal_op, instr_count); state = S_IDLE.
- States: S_IDLE, S_WAIT, S_DECODE (2-bit encoding).
- S_IDLE, ir_load=1, mem_valid=1: ir <= mem_data; go to S_DECODE.
- S_IDLE, ir_load=1, mem_valid=0: go to S_WAIT; ir unchanged.
- S_IDLE, ir_load=0: stay; mem_valid ignored.
- S_WAIT: hold until mem_valid=1, then ir <= mem_data and go to S_DECODE. ir_load level is ignored while waiting; the request is remembered.
- S_DECODE: always lasts one cycle, then S_IDLE. On its exit edge:
  - op_onehot <= (opcode < NOPS) ? 1<<opcode : 0
  - A_vec_4bits, rb_field, imm7 <= fields of ir
  - dec_valid <= 1 for exactly one cycle
  - instr_count <= instr_count+1, wrapping at 2^CNTW-1 -> 0
- Illegal opcode (opcode >= NOPS, i.e. 23..31): op_onehot = 0 and illegal_op <= 1.
  - illegal_op is sticky until illegal_clr.
  - illegal_clr and a new illegal decode on the same edge: set wins.
- Latency: capture at edge N, decoded outputs and dec_valid visible after edge N+1. Minimum 2 cycles per instruction.
- Decoded outputs hold their value between decodes; they are not cleared on return to S_IDLE.
- ir_load asserted in S_DECODE: ignored, no queuing. It must be re-asserted in S_IDLE.
- Reset asserted mid-S_WAIT or mid-S_DECODE: immediate return to S_IDLE with all outputs zero. No partial capture survives.
- No X propagation: default assignments cover every state; unused state encoding goes to S_IDLE.

Decomposition:
- Shared package (decode_pkg): opcode localparams OP_* (0..22) matching the controller's one-hot bit indices, NOPS, field bit positions (opcode [15:11], ra [10:7], rb [6:3], imm [6:0]), and the state encodings.
- One natural sub-module: opcode_onehot_dec. Purely combinational opcode -> one-hot plus illegal flag; the parent registers its output.

Test Plan:
- Reset then ir_load=1, mem_valid=1, mem_data=16'h6080 (opcode 12, ra 1) -> op_onehot=23'h001000 and A_vec_4bits=1 after 2 edges; dec_valid high for 1 cycle; instr_count=1.
- ir_load=1, mem_valid=0 for 3 cycles, then mem_valid=1 with 16'hB3FF (opcode 22) -> busy high 4 cycles; op_onehot=23'h400000; rb_field=4'hF, imm7=7'h7F.
- mem_data=16'hF800 (opcode 31) -> op_onehot=0, illegal_op=1 and held. illegal_clr pulse -> 0. illegal_clr coincident with another illegal decode -> stays 1.
- Preload instr_count to 16'hFFFF via 65535 back-to-back decodes, then one more -> instr_count wraps to 0.
- resetn low asynchronously during S_WAIT -> all outputs 0 immediately; after release, the next fetch behaves as in scenario 1.
- ir_load held high during S_DECODE -> no second capture until state returns to S_IDLE; exactly one dec_valid pulse per accepted fetch.
